lcd_pixel_fifo: RTL and testbench

Pixel buffer sitting directly upstream of the RGB LCD timing generator: accepts an RGB565 stream from a pixel producer (pattern or frame source) over a valid/ready handshake, holds it in a FIFO, and pops one pixel per active-pixel request from the timing generator. It drives the panel's 5/6/5 colour buses, aligns the producer's start-of-frame marker to the panel frame, and flags underflow and misalignment instead of tearing the image.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_fifo_ram.sv | 25 ++
 rtl/lcd_pixel_fifo.sv | 174 +++++++++++++++++
 tb/tb_lcd_pixel_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel path: RGB565 field layout, FIFO entry
// format and the pixel-buffer state encoding.
package lcd_pkg;

   localparam int RGB_W = 16;
   localparam int R_HI  = 15;
   localparam int R_LO  = 11;
   localparam int G_HI  = 10;
   localparam int G_LO  = 5;
   localparam int B_HI  = 4;
   localparam int B_LO  = 0;

   localparam logic [RGB_W-1:0] RGB_BLACK = '0;

   typedef struct packed {
      logic             sof;
      logic [RGB_W-1:0] data;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STREAM = 2'd2
   } lcd_state_e;

endpackage

// File: rtl/lcd_fifo_ram.sv
// Simple dual-port pixel storage: one write port, one registered read port.
// The array carries no reset; occupancy tracking in the parent decides validity.
module lcd_fifo_ram
   import lcd_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               PixelClk,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic [AW-1:0]      rd_addr,
   output logic [ENTRY_W-1:0] rd_data
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge PixelClk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/lcd_pixel_fifo.sv
// Pixel buffer between an RGB565 producer and the LCD timing generator; aligns
// the producer's start-of-frame to the panel frame and flags underflow/misalignment.
//
//   state  | meaning
//   HUNT   | discard beats until one carries SOF, which becomes the first entry
//   WAIT   | buffer filling; requests output black until FRAME_START sees SOF at head
//   STREAM | one pop per PIX_REQ until the frame's last pixel has been requested
module lcd_pixel_fifo
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = 480,
   parameter int V_ACTIVE = 272,
   parameter int DEPTH    = 512,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic          PixelClk,
   input  logic          nRST,
   input  logic          S_VALID,
   output logic          S_READY,
   input  logic [15:0]   S_DATA,
   input  logic          S_SOF,
   input  logic          FRAME_START,
   input  logic          PIX_REQ,
   input  logic          ERR_CLR,
   output logic [4:0]    LCD_R,
   output logic [5:0]    LCD_G,
   output logic [4:0]    LCD_B,
   output logic [AW:0]   FILL,
   output logic          UNDERFLOW,
   output logic          SYNC_ERR
);

   localparam int             TOTAL     = H_ACTIVE * V_ACTIVE;
   localparam int             PCW       = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [PCW-1:0] PIX_LAST  = PCW'(TOTAL - 1);
   localparam logic [AW:0]    FILL_FULL = (AW+1)'(DEPTH);

   lcd_state_e        state;
   logic [PCW-1:0]    pix_cnt;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_ptr_nxt;
   logic [ENTRY_W-1:0] ram_rd;
   logic              byp_q;
   fifo_entry_t       byp_data;
   fifo_entry_t       wr_entry;
   fifo_entry_t       head;
   logic              fifo_empty;
   logic              stream_req;
   logic              push;
   logic              pop;
   logic              flush;
   logic              underflow_set;
   logic              sync_set;
   logic              req_q;
   logic [RGB_W-1:0]  pix_q;

   assign S_READY = (state == ST_HUNT) || (FILL < FILL_FULL);

   // The RAM reads one cycle early at the next head address; a write landing on
   // that same address is forwarded so the head is always current.
   always_comb begin
      head = byp_q ? byp_data : fifo_entry_t'(ram_rd);
   end

   always_comb begin
      wr_entry      = '{sof: S_SOF, data: S_DATA};
      fifo_empty    = (FILL == '0);
      stream_req    = (state == ST_STREAM) && PIX_REQ;
      flush         = (state == ST_WAIT) && FRAME_START && !fifo_empty && !head.sof;
      push          = S_VALID && S_READY && !flush && ((state != ST_HUNT) || S_SOF);
      pop           = stream_req && !fifo_empty && (!head.sof || (pix_cnt == '0));
      underflow_set = stream_req && fifo_empty;
      sync_set      = flush || (stream_req && !fifo_empty && head.sof && (pix_cnt != '0));
      rd_ptr_nxt    = flush ? wr_ptr : rd_ptr + AW'(pop);
   end

   lcd_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .PixelClk (PixelClk),
      .wr_en    (push),
      .wr_addr  (wr_ptr),
      .wr_data  (wr_entry),
      .rd_addr  (rd_ptr_nxt),
      .rd_data  (ram_rd)
   );

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         FILL     <= '0;
         byp_q    <= 1'b0;
         byp_data <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr   <= rd_ptr_nxt;
         byp_q    <= push && (wr_ptr == rd_ptr_nxt);
         byp_data <= wr_entry;
         if (flush)
            FILL <= '0;
         else
            FILL <= FILL + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         state     <= ST_HUNT;
         pix_cnt   <= '0;
         UNDERFLOW <= 1'b0;
         SYNC_ERR  <= 1'b0;
      end else begin
         unique case (state)
            ST_HUNT: begin
               if (push)
                  state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (FRAME_START && !fifo_empty) begin
                  if (head.sof) begin
                     state   <= ST_STREAM;
                     pix_cnt <= '0;
                  end else begin
                     state <= ST_HUNT;
                  end
               end
            end
            ST_STREAM: begin
               if (PIX_REQ) begin
                  if (pix_cnt == PIX_LAST)
                     state <= ST_WAIT;
                  else
                     pix_cnt <= pix_cnt + PCW'(1);
               end
            end
            default: state <= ST_HUNT;
         endcase

         if (underflow_set)
            UNDERFLOW <= 1'b1;
         else if (ERR_CLR)
            UNDERFLOW <= 1'b0;

         if (sync_set)
            SYNC_ERR <= 1'b1;
         else if (ERR_CLR)
            SYNC_ERR <= 1'b0;
      end
   end

   // Two-stage pixel path: select head or black, then update the panel buses.
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         req_q <= 1'b0;
         pix_q <= RGB_BLACK;
         LCD_R <= '0;
         LCD_G <= '0;
         LCD_B <= '0;
      end else begin
         req_q <= PIX_REQ;
         pix_q <= pop ? head.data : RGB_BLACK;
         if (req_q) begin
            LCD_R <= pix_q[R_HI:R_LO];
            LCD_G <= pix_q[G_HI:G_LO];
            LCD_B <= pix_q[B_HI:B_LO];
         end
      end
   end

endmodule

// File: tb/tb_lcd_pixel_fifo.sv
// Directed bench for lcd_pixel_fifo with a queue-based reference model checked every cycle.
module tb_lcd_pixel_fifo;

   localparam int H = 4;
   localparam int V = 2;
   localparam int D = 8;
   localparam int TOT = H * V;
   localparam int M_HUNT = 0, M_WAIT = 1, M_STREAM = 2;

   logic        PixelClk = 1'b0;
   logic        nRST = 1'b0;
   logic        S_VALID = 1'b0;
   logic        S_READY;
   logic [15:0] S_DATA = '0;
   logic        S_SOF = 1'b0;
   logic        FRAME_START = 1'b0;
   logic        PIX_REQ = 1'b0;
   logic        ERR_CLR = 1'b0;
   logic [4:0]  LCD_R;
   logic [5:0]  LCD_G;
   logic [4:0]  LCD_B;
   logic [3:0]  FILL;
   logic        UNDERFLOW;
   logic        SYNC_ERR;
   logic [15:0] lcd_rgb;

   int vectors = 0;
   int errors  = 0;

   assign lcd_rgb = {LCD_R, LCD_G, LCD_B};

   lcd_pixel_fifo #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .DEPTH    (D),
      .AW       (3)
   ) dut (
      .PixelClk    (PixelClk),
      .nRST        (nRST),
      .S_VALID     (S_VALID),
      .S_READY     (S_READY),
      .S_DATA      (S_DATA),
      .S_SOF       (S_SOF),
      .FRAME_START (FRAME_START),
      .PIX_REQ     (PIX_REQ),
      .ERR_CLR     (ERR_CLR),
      .LCD_R       (LCD_R),
      .LCD_G       (LCD_G),
      .LCD_B       (LCD_B),
      .FILL        (FILL),
      .UNDERFLOW   (UNDERFLOW),
      .SYNC_ERR    (SYNC_ERR)
   );

   always #5 PixelClk = ~PixelClk;

   // Reference model: FIFO as a queue, colour deliveries as (edge, value) pairs.
   typedef struct {bit sof; bit [15:0] d;} ent_t;
   ent_t        mq[$];
   int          m_st;
   int          m_cnt;
   bit          m_uf, m_se;
   bit [15:0]   m_lcd;
   int          edge_n;
   int          due_q[$];
   bit [15:0]   val_q[$];

   always @(posedge PixelClk or negedge nRST) begin
      bit rdy, do_push, do_pop, do_flush, uf_set, se_set;
      bit [15:0] outv;
      if (!nRST) begin
         mq.delete(); due_q.delete(); val_q.delete();
         m_st = M_HUNT; m_cnt = 0; m_uf = 0; m_se = 0; m_lcd = 0; edge_n = 0;
      end else begin
         rdy      = (m_st == M_HUNT) || (mq.size() < D);
         do_push  = S_VALID && rdy && ((m_st != M_HUNT) || S_SOF);
         do_pop   = 0; do_flush = 0; uf_set = 0; se_set = 0; outv = 16'h0000;
         if (m_st == M_WAIT && FRAME_START && mq.size() > 0) begin
            if (mq[0].sof) begin m_st = M_STREAM; m_cnt = 0; end
            else begin do_flush = 1; se_set = 1; m_st = M_HUNT; end
         end else if (m_st == M_HUNT && do_push) begin
            m_st = M_WAIT;
         end else if (m_st == M_STREAM && PIX_REQ) begin
            if (mq.size() == 0) uf_set = 1;
            else if (mq[0].sof && m_cnt != 0) se_set = 1;
            else begin do_pop = 1; outv = mq[0].d; end
            if (m_cnt == TOT - 1) m_st = M_WAIT;
            else m_cnt++;
         end
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back('{sof: S_SOF, d: S_DATA});
         if (do_flush) mq.delete();
         if (uf_set) m_uf = 1; else if (ERR_CLR) m_uf = 0;
         if (se_set) m_se = 1; else if (ERR_CLR) m_se = 0;
         if (due_q.size() > 0 && due_q[0] == edge_n) begin
            m_lcd = val_q[0];
            void'(due_q.pop_front()); void'(val_q.pop_front());
         end
         if (PIX_REQ) begin due_q.push_back(edge_n + 1); val_q.push_back(outv); end
         edge_n++;
      end
   end

   always @(negedge PixelClk) begin
      bit exp_rdy;
      if (nRST) begin
         exp_rdy = (m_st == M_HUNT) || (mq.size() < D);
         vectors++;
         if (FILL !== 4'(mq.size()) || S_READY !== exp_rdy || UNDERFLOW !== m_uf ||
             SYNC_ERR !== m_se || lcd_rgb !== m_lcd) begin
            errors++;
            $display("FAIL cycle_model t=%0t fill=%0d/%0d rdy=%0b/%0b uf=%0b/%0b se=%0b/%0b lcd=%h/%h",
                     $time, FILL, mq.size(), S_READY, exp_rdy, UNDERFLOW, m_uf,
                     SYNC_ERR, m_se, lcd_rgb, m_lcd);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PixelClk);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      tick(); tick();
      nRST = 1'b1;
      tick();
   endtask

   task automatic push_beat(input logic [15:0] d, input logic sof);
      S_VALID = 1'b1; S_DATA = d; S_SOF = sof;
      tick();
      S_VALID = 1'b0; S_SOF = 1'b0; S_DATA = '0;
   endtask

   task automatic frame_start();
      FRAME_START = 1'b1;
      tick();
      FRAME_START = 1'b0;
      tick();
   endtask

   task automatic pix_reqs(input int n);
      for (int i = 0; i < n; i++) begin
         PIX_REQ = 1'b1;
         tick();
      end
      PIX_REQ = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      nRST = 1'b0;
      #1;
      check("reset_fill", 32'(FILL), 0);
      check("reset_ready", 32'(S_READY), 1);
      check("reset_lcd", 32'(lcd_rgb), 0);
      check("reset_flags", {UNDERFLOW, SYNC_ERR}, 0);
      tick();
      nRST = 1'b1;
      tick();

      // full frame of 8 pixels
      for (int i = 1; i <= 8; i++) push_beat(16'(i), i == 1);
      check("t1_fill_full", 32'(FILL), 8);
      check("t1_ready_low", 32'(S_READY), 0);
      frame_start();
      for (int i = 0; i < 8; i++) begin
         PIX_REQ = 1'b1;
         tick();
         if (i >= 1) check("t1_pixel", 32'(lcd_rgb), 32'(i));
      end
      PIX_REQ = 1'b0;
      tick();
      check("t1_pixel_last", 32'(lcd_rgb), 8);
      check("t1_flags", {UNDERFLOW, SYNC_ERR}, 0);
      check("t1_fill_empty", 32'(FILL), 0);
      push_beat(16'h1234, 1'b0);
      check("t1_back_in_wait", 32'(FILL), 1);

      // hunt discards non-SOF beats
      do_reset();
      push_beat(16'h1111, 1'b0);
      push_beat(16'h2222, 1'b0);
      push_beat(16'h3333, 1'b0);
      check("t2_hunt_discard", 32'(FILL), 0);
      push_beat(16'hF800, 1'b1);
      check("t2_sof_kept", 32'(FILL), 1);
      frame_start();
      pix_reqs(1);
      tick();
      check("t2_red", {LCD_R, LCD_G, LCD_B}, 32'hF800);
      check("t2_r31", 32'(LCD_R), 31);

      // underflow: only 5 pixels in this frame
      for (int i = 2; i <= 5; i++) push_beat(16'(i), 1'b0);
      pix_reqs(7);
      tick(); tick();
      check("t3_underflow", 32'(UNDERFLOW), 1);
      check("t3_black_tail", 32'(lcd_rgb), 0);
      tick(); tick(); tick();
      check("t3_uf_sticky", 32'(UNDERFLOW), 1);
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0;
      check("t3_uf_cleared", 32'(UNDERFLOW), 0);

      // short frame followed by next SOF
      for (int i = 1; i <= 6; i++) push_beat(16'h0A00 + 16'(i), i == 1);
      push_beat(16'h0B01, 1'b1);
      push_beat(16'h0B02, 1'b0);
      check("t4_fill", 32'(FILL), 8);
      frame_start();
      pix_reqs(8);
      tick(); tick();
      check("t4_sync_err", 32'(SYNC_ERR), 1);
      check("t4_black", 32'(lcd_rgb), 0);
      check("t4_sof_held", 32'(FILL), 2);
      frame_start();
      pix_reqs(1);
      tick();
      check("t4_next_frame", 32'(lcd_rgb), 32'h0B01);

      // backpressure and simultaneous push/pop
      S_VALID = 1'b1; S_DATA = 16'h07E0; S_SOF = 1'b0;
      for (int k = 0; k < 20 && S_READY; k++) tick();
      check("t5_full_fill", 32'(FILL), 8);
      check("t5_full_ready", 32'(S_READY), 0);
      PIX_REQ = 1'b1;
      tick();
      check("t5_pop_fill", 32'(FILL), 7);
      check("t5_pop_ready", 32'(S_READY), 1);
      tick();
      check("t5_pushpop_fill", 32'(FILL), 7);
      PIX_REQ = 1'b0; S_VALID = 1'b0; S_DATA = '0;
      tick();
      check("t5_green", 32'(LCD_G), 63);

      // async reset mid-frame
      #3;
      nRST = 1'b0;
      #1;
      check("t6_lcd", 32'(lcd_rgb), 0);
      check("t6_fill", 32'(FILL), 0);
      check("t6_ready", 32'(S_READY), 1);
      check("t6_flags", {UNDERFLOW, SYNC_ERR}, 0);
      tick();
      nRST = 1'b1;
      tick();
      push_beat(16'h4444, 1'b0);
      check("t6_hunt", 32'(FILL), 0);
      push_beat(16'h5555, 1'b1);
      check("t6_hunt_sof", 32'(FILL), 1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
